// File: rtl/fsm_x_serializer.sv
// fsm_x_serializer: parallel-to-serial front end for the A/B state machine's
// serial input x. A word is accepted over valid/ready and shifted out one bit
// per CLK on x, qualified by x_valid. Consecutive words stream with no gap.
// Optional build macro FSM_X_SERIALIZER_PARITY_EN appends an even-parity bit
// after the data bits of every word.
module fsm_x_serializer #(
  parameter int WIDTH     = 8,
  parameter int CNTW      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic [CNTW-1:0]  bit_cnt
);

`ifdef FSM_X_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             x_nxt, xv_nxt, done_nxt;
  logic [CNTW-1:0]  cnt_nxt;
  logic             last, accept;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] load_rest, sreg_shift;
`ifdef FSM_X_SERIALIZER_PARITY_EN
  logic             par_r, par_nxt;
`endif

  // Bit-order steering: the first bit goes straight to x on accept, the rest
  // sit in sreg and leave from the end nearest the send direction.
  assign first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign load_rest  = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
  assign next_bit   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign last       = (bit_cnt == CNTW'(WIDTH-1));

  // Ready is combinational so a reload lands on the edge after the final bit.
`ifdef FSM_X_SERIALIZER_PARITY_EN
  assign load_ready = !hold && (state == IDLE || state == PAR);
`else
  assign load_ready = !hold && (state == IDLE || (state == SHIFT && last));
`endif
  assign accept = load_valid && load_ready;

  // State and output registers; reset discards any partial word.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      sreg    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
`ifdef FSM_X_SERIALIZER_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      x       <= x_nxt;
      x_valid <= xv_nxt;
      done    <= done_nxt;
      bit_cnt <= cnt_nxt;
`ifdef FSM_X_SERIALIZER_PARITY_EN
      par_r   <= par_nxt;
`endif
    end
  end

  // Next-state and next-output logic; hold freezes everything except done.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    x_nxt     = x;
    xv_nxt    = x_valid;
    cnt_nxt   = bit_cnt;
    done_nxt  = 1'b0;
`ifdef FSM_X_SERIALIZER_PARITY_EN
    par_nxt   = par_r;
`endif
    if (!hold) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = SHIFT;
            sreg_nxt  = load_rest;
            x_nxt     = first_bit;
            xv_nxt    = 1'b1;
            cnt_nxt   = '0;
`ifdef FSM_X_SERIALIZER_PARITY_EN
            par_nxt   = ^load_data;
`endif
          end
        end
        SHIFT: begin
          if (!last) begin
            sreg_nxt = sreg_shift;
            x_nxt    = next_bit;
            cnt_nxt  = bit_cnt + CNTW'(1);
          end else begin
`ifdef FSM_X_SERIALIZER_PARITY_EN
            state_nxt = PAR;
            x_nxt     = par_r;
            cnt_nxt   = CNTW'(WIDTH);
`else
            done_nxt = 1'b1;
            if (accept) begin
              sreg_nxt = load_rest;
              x_nxt    = first_bit;
              xv_nxt   = 1'b1;
              cnt_nxt  = '0;
            end else begin
              state_nxt = IDLE;
              sreg_nxt  = '0;
              x_nxt     = 1'b0;
              xv_nxt    = 1'b0;
              cnt_nxt   = '0;
            end
`endif
          end
        end
`ifdef FSM_X_SERIALIZER_PARITY_EN
        PAR: begin
          done_nxt = 1'b1;
          if (accept) begin
            state_nxt = SHIFT;
            sreg_nxt  = load_rest;
            x_nxt     = first_bit;
            xv_nxt    = 1'b1;
            cnt_nxt   = '0;
            par_nxt   = ^load_data;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            x_nxt     = 1'b0;
            xv_nxt    = 1'b0;
            cnt_nxt   = '0;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          sreg_nxt  = '0;
          x_nxt     = 1'b0;
          xv_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_x_serializer.sv
module tb_fsm_x_serializer;

`ifdef FSM_X_SERIALIZER_PARITY_EN
  localparam int WLEN = 9;
`else
  localparam int WLEN = 8;
`endif

  logic       CLK, RESETn, load_valid, hold;
  logic [7:0] load_data;
  logic       load_ready, x, x_valid, done;
  logic [3:0] bit_cnt;
  logic       load_ready_l, x_l, x_valid_l, done_l;
  logic [3:0] bit_cnt_l;

  int ntests = 0;
  int nfail  = 0;

  fsm_x_serializer #(.WIDTH(8), .CNTW(4), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RESETn(RESETn), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .hold(hold), .x(x), .x_valid(x_valid),
    .done(done), .bit_cnt(bit_cnt));

  fsm_x_serializer #(.WIDTH(8), .CNTW(4), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RESETn(RESETn), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_l), .hold(hold), .x(x_l), .x_valid(x_valid_l),
    .done(done_l), .bit_cnt(bit_cnt_l));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic ok);
    ntests++;
    if (ok !== 1'b1) begin
      nfail++;
      $error("FAIL %s observed=mismatch expected=match", tag);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic [7:0] d, input logic pexp);
    load_valid = 1'b1;
    load_data  = d;
    chk("w_ready", load_ready === 1'b1);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("w_x_msb", x === d[7-k]);
      chk("w_x_lsb", x_l === d[k]);
      chk("w_cnt", bit_cnt === 4'(k));
      chk("w_cnt_l", bit_cnt_l === 4'(k));
      chk("w_xv", x_valid === 1'b1);
      chk("w_done", done === 1'b0);
      tick();
    end
`ifdef FSM_X_SERIALIZER_PARITY_EN
    chk("p_x", x === pexp);
    chk("p_x_l", x_l === pexp);
    chk("p_cnt", bit_cnt === 4'd8);
    chk("p_xv", x_valid === 1'b1);
    chk("p_done", done === 1'b0);
    tick();
`else
    if (pexp === 1'bx) $display("unreachable");
`endif
    chk("end_done", done === 1'b1);
    chk("end_done_l", done_l === 1'b1);
    chk("end_xv", x_valid === 1'b0);
    chk("end_x", x === 1'b0);
    chk("end_cnt", bit_cnt === 4'd0);
    tick();
    chk("end_done_clr", done === 1'b0);
  endtask

  logic [17:0] stream;
  int          bi;

  initial begin
    RESETn = 1'b0; load_valid = 1'b0; load_data = 8'h00; hold = 1'b0;
`ifdef FSM_X_SERIALIZER_PARITY_EN
    stream = 18'b11110000_0_00001111_0;
`else
    stream = {2'b00, 16'b1111_0000_0000_1111};
`endif

    tick();
    chk("rst_x", x === 1'b0);
    chk("rst_xv", x_valid === 1'b0);
    chk("rst_done", done === 1'b0);
    chk("rst_cnt", bit_cnt === 4'd0);
    RESETn = 1'b1;
    tick();
    chk("idle_ready", load_ready === 1'b1);
    chk("idle_xv", x_valid === 1'b0);

    word(8'hA5, 1'b0);
    word(8'h01, 1'b1);

    load_valid = 1'b1;
    load_data  = 8'hF0;
    tick();
    for (int c = 0; c <= 2*WLEN; c++) begin
      if (c < 2*WLEN) begin
        chk("b2b_x", x === stream[2*WLEN-1-c]);
        chk("b2b_xv", x_valid === 1'b1);
        chk("b2b_done", done === (c == WLEN));
      end else begin
        chk("b2b_end_xv", x_valid === 1'b0);
        chk("b2b_end_done", done === 1'b1);
      end
      if (c == 0) begin
        chk("b2b_notready", load_ready === 1'b0);
        load_data = 8'h0F;
      end
      if (c == WLEN-1) chk("b2b_ready", load_ready === 1'b1);
      if (c == WLEN) load_valid = 1'b0;
      tick();
    end
    chk("b2b_done_clr", done === 1'b0);

    load_valid = 1'b1;
    load_data  = 8'h80;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      bi = (c <= 2) ? c : ((c <= 5) ? 2 : c - 3);
      chk("hold_cnt", bit_cnt === 4'(bi));
      chk("hold_x", x === (bi == 0));
      chk("hold_xv", x_valid === 1'b1);
      chk("hold_done", done === 1'b0);
      if (c == 2) hold = 1'b1;
      if (c >= 2 && c <= 5) chk("hold_ready", load_ready === 1'b0);
      if (c == 5) hold = 1'b0;
      tick();
    end
`ifdef FSM_X_SERIALIZER_PARITY_EN
    chk("hold_par", x === 1'b1);
    chk("hold_par_cnt", bit_cnt === 4'd8);
    tick();
`endif
    chk("hold_end_done", done === 1'b1);
    chk("hold_end_xv", x_valid === 1'b0);
    tick();

    load_valid = 1'b1;
    load_data  = 8'h00;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < WLEN-1; c++) tick();
    hold = 1'b1;
    tick();
    tick();
    chk("hl_done_held", done === 1'b0);
    chk("hl_xv_held", x_valid === 1'b1);
    chk("hl_cnt_held", bit_cnt === 4'(WLEN-1));
    hold = 1'b0;
    tick();
    chk("hl_done", done === 1'b1);
    tick();

    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("mr_cnt4", bit_cnt === 4'd4);
    chk("mr_x1", x === 1'b1);
    #2 RESETn = 1'b0;
    #1;
    chk("mr_x", x === 1'b0);
    chk("mr_xv", x_valid === 1'b0);
    chk("mr_done", done === 1'b0);
    chk("mr_cnt", bit_cnt === 4'd0);
    RESETn = 1'b1;
    tick();
    chk("mr_ready", load_ready === 1'b1);
    word(8'h3C, 1'b0);

    word(8'h07, 1'b1);
    word(8'hA5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
